// File: rtl/distortion_gain_sequencer_if.sv
// Control/status bundle between the board keys/switches and the distortion
// gain sequencer.
//   key3, key2    : pushbuttons, active-low (key3 decrements, key2 increments)
//   SW9, SW8      : mode switches (SW9 has priority)
//   sample_tick   : one-clock pulse per audio sample
//   gainNum       : gain numerator applied to the datapath (signed 16)
//   gainDen       : gain denominator, always 1 (signed 16)
//   target_gain   : debounced user target gain (signed 16)
//   mode          : distortion mode (0 bypass, 1, 2)
//   mute          : forces the datapath output to zero while high
//   busy          : high whenever the mode handshake is in progress
// The master modport is the board/control side; the slave modport is the sequencer.
interface distortion_gain_sequencer_if;
    logic               key3;
    logic               key2;
    logic               SW9;
    logic               SW8;
    logic               sample_tick;
    logic signed [15:0] gainNum;
    logic signed [15:0] gainDen;
    logic signed [15:0] target_gain;
    logic [1:0]         mode;
    logic               mute;
    logic               busy;

    modport master (
        output key3, key2, SW9, SW8, sample_tick,
        input  gainNum, gainDen, target_gain, mode, mute, busy
    );

    modport slave (
        input  key3, key2, SW9, SW8, sample_tick,
        output gainNum, gainDen, target_gain, mode, mute, busy
    );
endinterface

// File: rtl/distortion_gain_sequencer.sv
// Distortion gain/mode sequencer. Keys and switches are synchronized and
// debounced; keys produce press and auto-repeat events that step a saturated
// target gain; the applied gain ramps one step per audio sample toward the
// target; mode changes go through a timed mute -> swap -> settle handshake.
// Ports:
//   CLK     : system clock
//   RESET_N : synchronous active-low reset
//   bus     : slave side of distortion_gain_sequencer_if (keys, switches,
//             sample tick in; gain, mode, mute, busy out)
module distortion_gain_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 24000,
    parameter int REPEAT_RATE     = 4800,
    parameter int GAIN_MIN        = 1,
    parameter int GAIN_MAX        = 50,
    parameter int MUTE_SAMPLES    = 64
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    distortion_gain_sequencer_if.slave  bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_DELAY + 1);
    localparam int MUTE_W = $clog2(MUTE_SAMPLES + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    // After a repeat fires the counter restarts here, so the next one is REPEAT_RATE ticks away.
    localparam logic [REP_W-1:0]   REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [MUTE_W-1:0]  MUTE_LAST  = MUTE_W'(MUTE_SAMPLES - 1);
    localparam logic signed [15:0] GMIN       = 16'(GAIN_MIN);
    localparam logic signed [15:0] GMAX       = 16'(GAIN_MAX);

    // Bit order: [0] key2, [1] key3, [2] SW8, [3] SW9. Idle = keys released, switches off.
    localparam logic [3:0] IDLE_LEVELS = 4'b0011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MUTING = 2'd1,
        ST_SWAP   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    logic [3:0]             raw_s;
    logic [3:0]             sync1_r;
    logic [3:0]             sync2_r;
    logic [3:0]             db_r;
    logic [DB_W-1:0]        db_cnt_r [4];
    logic [1:0]             key_prev_r;
    logic [REP_W-1:0]       rep_cnt_r [2];
    logic                   up_evt_s;
    logic                   dn_evt_s;
    logic signed [15:0]     target_r;
    logic signed [15:0]     target_next_s;
    logic signed [15:0]     gain_r;
    logic signed [15:0]     gain_next_s;
    logic [1:0]             req_mode_s;
    state_t                 state_r;
    state_t                 state_next_s;
    logic [MUTE_W-1:0]      mute_cnt_r;
    logic [MUTE_W-1:0]      mute_cnt_next_s;
    logic [1:0]             mode_r;
    logic [1:0]             mode_next_s;
    logic                   mute_r;
    logic                   busy_r;

    assign raw_s = {bus.SW9, bus.SW8, bus.key3, bus.key2};

    // Two-flop synchronizer for all key/switch inputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1_r <= IDLE_LEVELS;
            sync2_r <= IDLE_LEVELS;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debouncers: accept a level only after it has differed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            db_r       <= IDLE_LEVELS;
            key_prev_r <= 2'b11;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            key_prev_r <= db_r[1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_r[i]     <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Auto-repeat tick counters, one per key; released key clears its counter.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rep_cnt_r[0] <= '0;
            rep_cnt_r[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (db_r[k]) begin
                    rep_cnt_r[k] <= '0;
                end else if (bus.sample_tick && (rep_cnt_r[k] == REP_LAST)) begin
                    rep_cnt_r[k] <= REP_RELOAD;
                end else if (bus.sample_tick) begin
                    rep_cnt_r[k] <= rep_cnt_r[k] + REP_W'(1);
                end else begin
                    rep_cnt_r[k] <= rep_cnt_r[k];
                end
            end
        end
    end

    // Step events: press edge or auto-repeat; saturated target update; ramp toward target.
    always_comb begin
        up_evt_s = (key_prev_r[0] & ~db_r[0]) |
                   (~db_r[0] & bus.sample_tick & (rep_cnt_r[0] == REP_LAST));
        dn_evt_s = (key_prev_r[1] & ~db_r[1]) |
                   (~db_r[1] & bus.sample_tick & (rep_cnt_r[1] == REP_LAST));

        target_next_s = target_r;
        if (up_evt_s && !dn_evt_s && (target_r < GMAX)) begin
            target_next_s = target_r + 16'sd1;
        end else if (dn_evt_s && !up_evt_s && (target_r > GMIN)) begin
            target_next_s = target_r - 16'sd1;
        end else begin
            target_next_s = target_r;
        end

        gain_next_s = gain_r;
        if (bus.sample_tick && (gain_r < target_r)) begin
            gain_next_s = gain_r + 16'sd1;
        end else if (bus.sample_tick && (gain_r > target_r)) begin
            gain_next_s = gain_r - 16'sd1;
        end else begin
            gain_next_s = gain_r;
        end
    end

    // Requested mode from the debounced switches; SW9 wins over SW8.
    always_comb begin
        req_mode_s = 2'd0;
        if (db_r[3]) begin
            req_mode_s = 2'd1;
        end else if (db_r[2]) begin
            req_mode_s = 2'd2;
        end else begin
            req_mode_s = 2'd0;
        end
    end

    // Mode handshake next-state logic.
    always_comb begin
        state_next_s    = state_r;
        mute_cnt_next_s = mute_cnt_r;
        mode_next_s     = mode_r;
        case (state_r)
            ST_RUN: begin
                mute_cnt_next_s = '0;
                if (req_mode_s != mode_r) begin
                    state_next_s = ST_MUTING;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_MUTING, ST_SETTLE: begin
                if (bus.sample_tick && (mute_cnt_r == MUTE_LAST)) begin
                    state_next_s    = (state_r == ST_MUTING) ? ST_SWAP : ST_RUN;
                    mute_cnt_next_s = '0;
                end else if (bus.sample_tick) begin
                    mute_cnt_next_s = mute_cnt_r + MUTE_W'(1);
                end else begin
                    mute_cnt_next_s = mute_cnt_r;
                end
            end
            ST_SWAP: begin
                mode_next_s     = req_mode_s;
                state_next_s    = ST_SETTLE;
                mute_cnt_next_s = '0;
            end
            default: begin
                state_next_s    = ST_RUN;
                mute_cnt_next_s = '0;
            end
        endcase
    end

    // State, gain and output registers; mute/busy follow the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r    <= ST_RUN;
            mute_cnt_r <= '0;
            mode_r     <= 2'd0;
            mute_r     <= 1'b0;
            busy_r     <= 1'b0;
            target_r   <= 16'sd1;
            gain_r     <= 16'sd1;
        end else begin
            state_r    <= state_next_s;
            mute_cnt_r <= mute_cnt_next_s;
            mode_r     <= mode_next_s;
            mute_r     <= (state_next_s != ST_RUN);
            busy_r     <= (state_next_s != ST_RUN);
            target_r   <= target_next_s;
            gain_r     <= gain_next_s;
        end
    end

    assign bus.gainNum     = gain_r;
    assign bus.gainDen     = 16'sd1;
    assign bus.target_gain = target_r;
    assign bus.mode        = mode_r;
    assign bus.mute        = mute_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_distortion_gain_sequencer.sv
// Self-checking bench for distortion_gain_sequencer with short timing
// parameters (debounce 4, repeat delay 8, repeat rate 2, mute 3 samples).
module tb_distortion_gain_sequencer;
    logic clk;
    logic RESET_N;
    int   pass_cnt;
    int   total_cnt;
    logic range_err;

    distortion_gain_sequencer_if bus ();

    distortion_gain_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_RATE     (2),
        .GAIN_MIN        (1),
        .GAIN_MAX        (50),
        .MUTE_SAMPLES    (3)
    ) dut (
        .CLK     (clk),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial range_err = 1'b0;
    // Flags any target outside the saturation range while out of reset.
    always @(posedge clk) begin
        if (RESET_N && ((bus.target_gain > 16'sd50) || (bus.target_gain < 16'sd1))) begin
            range_err <= 1'b1;
        end
    end

    typedef struct {
        logic       sw9;
        logic       sw8;
        logic [1:0] exp_mode;
        logic       exp_busy;
    } mode_vec_t;

    mode_vec_t mode_vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One sample tick: high for one clock, then four clocks low.
    task automatic tick_n(input int n);
        repeat (n) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            idle(4);
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        mode_vecs[0] = '{sw9: 1'b0, sw8: 1'b1, exp_mode: 2'd2, exp_busy: 1'b1};
        mode_vecs[1] = '{sw9: 1'b1, sw8: 1'b1, exp_mode: 2'd1, exp_busy: 1'b1};
        mode_vecs[2] = '{sw9: 1'b1, sw8: 1'b0, exp_mode: 2'd1, exp_busy: 1'b0};
        mode_vecs[3] = '{sw9: 1'b0, sw8: 1'b0, exp_mode: 2'd0, exp_busy: 1'b1};
        mode_vecs[4] = '{sw9: 1'b0, sw8: 1'b0, exp_mode: 2'd0, exp_busy: 1'b0};
        mode_vecs[5] = '{sw9: 1'b1, sw8: 1'b0, exp_mode: 2'd1, exp_busy: 1'b1};
        mode_vecs[6] = '{sw9: 1'b0, sw8: 1'b1, exp_mode: 2'd2, exp_busy: 1'b1};
        mode_vecs[7] = '{sw9: 1'b0, sw8: 1'b0, exp_mode: 2'd0, exp_busy: 1'b1};

        RESET_N         = 1'b0;
        bus.key2        = 1'b1;
        bus.key3        = 1'b1;
        bus.SW9         = 1'b0;
        bus.SW8         = 1'b0;
        bus.sample_tick = 1'b0;

        // Reset with keys bouncing.
        for (int i = 0; i < 3; i++) begin
            bus.key2 = ~bus.key2;
            bus.key3 = bus.key2;
            step();
        end
        check("reset_gainNum", int'(bus.gainNum), 1);
        check("reset_gainDen", int'(bus.gainDen), 1);
        check("reset_target", int'(bus.target_gain), 1);
        check("reset_mode", int'(bus.mode), 0);
        check("reset_mute", int'(bus.mute), 0);
        check("reset_busy", int'(bus.busy), 0);
        RESET_N  = 1'b1;
        bus.key2 = 1'b1;
        bus.key3 = 1'b1;
        idle(10);

        // key2 with 2-clock glitches, then stable low.
        for (int i = 0; i < 2; i++) begin
            bus.key2 = 1'b0;
            idle(2);
            bus.key2 = 1'b1;
            idle(2);
        end
        check("bounce_no_step", int'(bus.target_gain), 1);
        bus.key2 = 1'b0;
        idle(6);
        check("press_edge6", int'(bus.target_gain), 1);
        step();
        check("press_edge7", int'(bus.target_gain), 2);
        check("press_gain_before_tick", int'(bus.gainNum), 1);
        tick_n(1);
        check("ramp_first_tick", int'(bus.gainNum), 2);

        // Keep holding: 30 ticks total since the press.
        tick_n(29);
        check("repeat_30_ticks_target", int'(bus.target_gain), 14);
        check("repeat_30_ticks_gain", int'(bus.gainNum), 13);
        tick_n(80);
        check("saturate_max_target", int'(bus.target_gain), 50);
        check("saturate_max_gain", int'(bus.gainNum), 50);
        check("gainDen_const", int'(bus.gainDen), 1);
        bus.key2 = 1'b1;
        idle(10);

        // Hold key3 down to 10.
        bus.key3 = 1'b0;
        idle(7);
        check("key3_press", int'(bus.target_gain), 49);
        tick_n(84);
        check("key3_repeat_to_10", int'(bus.target_gain), 10);
        bus.key3 = 1'b1;
        idle(10);
        check("key3_release", int'(bus.target_gain), 10);

        // Both keys in the same cycle cancel, including their repeats.
        bus.key2 = 1'b0;
        bus.key3 = 1'b0;
        idle(10);
        check("simul_press", int'(bus.target_gain), 10);
        tick_n(10);
        check("simul_repeat", int'(bus.target_gain), 10);
        bus.key2 = 1'b1;
        bus.key3 = 1'b1;
        idle(10);

        // Reset mid-run with key3 bouncing, then key3 at the lower bound.
        RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.key3 = ~bus.key3;
            step();
        end
        RESET_N  = 1'b1;
        bus.key3 = 1'b1;
        check("reset2_target", int'(bus.target_gain), 1);
        check("reset2_gain", int'(bus.gainNum), 1);
        idle(10);
        bus.key3 = 1'b0;
        idle(10);
        check("min_press", int'(bus.target_gain), 1);
        tick_n(10);
        check("min_repeat", int'(bus.target_gain), 1);
        check("range_monitor", int'(range_err), 0);
        bus.key3 = 1'b1;
        idle(10);

        // SW8 from mode 0: full mute/swap/settle.
        bus.SW8 = 1'b1;
        idle(6);
        check("sw8_mute_edge6", int'(bus.mute), 0);
        step();
        check("sw8_mute_edge7", int'(bus.mute), 1);
        check("sw8_busy", int'(bus.busy), 1);
        tick_n(2);
        check("sw8_mode_2ticks", int'(bus.mode), 0);
        tick_n(1);
        check("sw8_mode_swapped", int'(bus.mode), 2);
        check("sw8_mute_settle", int'(bus.mute), 1);
        tick_n(2);
        check("sw8_settle_2ticks", int'(bus.mute), 1);
        tick_n(1);
        check("sw8_mute_fall", int'(bus.mute), 0);
        check("sw8_busy_fall", int'(bus.busy), 0);
        check("sw8_final_mode", int'(bus.mode), 2);

        // Back to mode 0; SW9 raised during SETTLE starts another cycle.
        bus.SW8 = 1'b0;
        idle(8);
        check("sw0_busy", int'(bus.busy), 1);
        tick_n(3);
        check("sw0_mode", int'(bus.mode), 0);
        bus.SW9 = 1'b1;
        idle(8);
        check("settle_hold_busy", int'(bus.busy), 1);
        tick_n(3);
        check("second_cycle_mute", int'(bus.mute), 1);
        tick_n(3);
        check("second_cycle_mode", int'(bus.mode), 1);
        tick_n(3);
        check("second_cycle_done", int'(bus.mute), 0);

        // Reset in the middle of MUTING.
        bus.SW9 = 1'b0;
        idle(8);
        check("pre_reset_muting", int'(bus.mute), 1);
        tick_n(1);
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        check("reset_mid_mute", int'(bus.mute), 0);
        check("reset_mid_mode", int'(bus.mode), 0);
        check("reset_mid_busy", int'(bus.busy), 0);
        idle(10);
        check("post_reset_idle", int'(bus.busy), 0);

        // Table-driven mode decode through the handshake.
        for (int v = 0; v < 8; v++) begin
            bus.SW9 = mode_vecs[v].sw9;
            bus.SW8 = mode_vecs[v].sw8;
            idle(8);
            check($sformatf("vec%0d_busy", v), int'(bus.busy), int'(mode_vecs[v].exp_busy));
            tick_n(8);
            check($sformatf("vec%0d_mode", v), int'(bus.mode), int'(mode_vecs[v].exp_mode));
            check($sformatf("vec%0d_mute", v), int'(bus.mute), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/distortion_gain_sequencer.md
# distortion_gain_sequencer

Sequences the distortion stage's gain and mode so that user edits reach the audio datapath without clicks. Pushbuttons are debounced, with press-and-hold auto-repeat, to produce a target gain. The applied gain ramps toward that target one step per audio sample. Mode changes from the switches are wrapped in a timed mute/swap/settle handshake. The block sits between the board keys/switches and the distortion datapath, and its `gainNum`/`gainDen`/`mode` outputs drive that datapath directly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a key/switch level change (10 ms at 50 MHz)
- REPEAT_DELAY, 24000, sample ticks a key must stay held before the first auto-repeat
- REPEAT_RATE, 4800, sample ticks between subsequent auto-repeats
- GAIN_MIN, 1, lower saturation bound of the gain
- GAIN_MAX, 50, upper saturation bound of the gain
- MUTE_SAMPLES, 64, sample ticks spent in each mute phase

Ports:
- CLK  in  1  system clock; the only clock
- RESET_N  in  1  reset, synchronous, active-low
- key3  in  1  pushbutton, active-low; decrements the gain
- key2  in  1  pushbutton, active-low; increments the gain
- SW9  in  1  mode switch (priority)
- SW8  in  1  mode switch
- sample_tick  in  1  one-CLK pulse per audio sample
- gainNum  out  16 signed  gain numerator applied to the datapath
- gainDen  out  16 signed  gain denominator; constant 1
- target_gain  out  16 signed  debounced user target
- mode  out  2  distortion mode (0 bypass, 1, 2)
- mute  out  1  forces datapath output to zero while high
- busy  out  1  high whenever the FSM is not in RUN

## Operation
- Reset (RESET_N low at a CLK edge) sets: gainNum=1, gainDen=1, target_gain=1, mode=0, mute=0, busy=0, FSM=RUN. Debounced keys are set to released (1), debounced switches to 0, and all counters to 0. Reset has priority over every other event, including mid-handshake; the FSM returns to RUN and mute drops.
- Input conditioning: every key/switch input passes through a 2-flop synchronizer and then a debouncer. The debounced level takes the synchronized value once that value has differed from it for DEBOUNCE_CYCLES consecutive clocks. Any match resets the count.
- Press event: a debounced key transition 1->0. Each press event steps target_gain by ±1.
- Auto-repeat: while a debounced key stays 0, count sample ticks. The first repeat event fires at REPEAT_DELAY ticks, then one every REPEAT_RATE ticks. Release clears the count.
- Simultaneous events: if key2 and key3 events occur in the same clock, they cancel and target_gain is unchanged.
- Saturation: target_gain is clamped to [GAIN_MIN, GAIN_MAX]. Events beyond a bound are ignored.
- Ramp: on each sample_tick, gainNum moves 1 toward target_gain (+1 if below, −1 if above, hold if equal). The ramp runs in every FSM state.
- Mode decode: debounced SW9=1 -> 1; else SW8=1 -> 2; else 0. This is the requested mode.
- FSM:
  - RUN: mute=0. If requested ≠ mode, go to MUTING next clock.
  - MUTING: mute=1, busy=1. Count sample ticks; after MUTE_SAMPLES ticks, go to SWAP.
  - SWAP: one clock. mode <= requested mode as sampled in this cycle; mute stays 1. Go to SETTLE.
  - SETTLE: mute=1. Count MUTE_SAMPLES ticks, then go to RUN. RUN re-checks the request, so a switch change during the handshake triggers a new cycle.

## Timing
- Key to target: target_gain updates on the CLK edge exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw key low. Breakdown: 2 synchronizer edges, DEBOUNCE_CYCLES to flip the debounced level, 1 edge for the update.
- Switch to mute: mute rises DEBOUNCE_CYCLES+3 edges after the raw switch change. Breakdown: DEBOUNCE_CYCLES+2 edges to the debounced switch level, then 1 edge for RUN->MUTING.
- Mute duration: mode changes after MUTE_SAMPLES ticks; mute falls after a further MUTE_SAMPLES ticks plus one SWAP clock.
- Ramp: gainNum changes on the edge that registers sample_tick high. A step of N takes N ticks.
- All outputs are registered. gainDen is constant 1 at all times.

## Test plan
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=2, MUTE_SAMPLES=3, and sample_tick every 5 clocks.
- Reset: hold RESET_N low for 3 clocks with keys bouncing. Required: gainNum=1, target_gain=1, mode=0, mute=0, busy=0.
- Press key2 for 12 clocks with 2-clock bounce glitches. Required: exactly one step, target_gain 1->2 on edge 7 after stable low; gainNum reaches 2 on the next tick.
- Hold key2 for 30 ticks. Required: target_gain = 1+1+(1+(30−8)/2) = 14. Continue holding to saturation. Required: target_gain stops at 50, never 51.
- Press key2 and key3 in the same cycle at target=10. Required: target stays 10. Press key3 at target=1. Required: target stays 1.
- Set SW8=1 from mode 0. Required: mute rises, mode=2 after 3 ticks, mute falls 3 ticks later, busy tracks mute.
- During SETTLE set SW9=1. Required: a second mute cycle ending in mode=1. RESET_N low mid-MUTING. Required: mute=0, mode=0 on the next edge.
